// File: rtl/ysyx_pkg.sv
// ----------------------------------------------------------------------------
// ysyx_pkg
// Shared encodings for the NPC execute stage:
//   - ALU function codes driven on alu_func
//   - br_op encodings (none / jal / jalr / conditional with RISC-V funct3)
//   - SrcA / SrcB operand select encodings
// No ports; imported by ysyx_exu and ysyx_exu_bru.
// ----------------------------------------------------------------------------
package ysyx_pkg;

    // ALU function codes (bit 3 selects the "alternate" op, as in funct7[5])
    typedef enum logic [3:0] {
        ALU_ADD   = 4'b0000,
        ALU_SLL   = 4'b0001,
        ALU_SLT   = 4'b0010,
        ALU_SLTU  = 4'b0011,
        ALU_XOR   = 4'b0100,
        ALU_SRL   = 4'b0101,
        ALU_OR    = 4'b0110,
        ALU_AND   = 4'b0111,
        ALU_SUB   = 4'b1000,
        ALU_SRA   = 4'b1101,
        ALU_PASSB = 4'b1110
    } alu_func_e;

    // Unconditional branch-unit operations; any code with bit 3 set is a
    // conditional branch whose low three bits carry funct3.
    typedef enum logic [3:0] {
        BR_NONE = 4'b0000,
        BR_JAL  = 4'b0010,
        BR_JALR = 4'b0011
    } br_op_e;

    localparam int BR_COND_BIT = 3;

    typedef enum logic [2:0] {
        F3_BEQ  = 3'b000,
        F3_BNE  = 3'b001,
        F3_BLT  = 3'b100,
        F3_BGE  = 3'b101,
        F3_BLTU = 3'b110,
        F3_BGEU = 3'b111
    } br_f3_e;

    typedef enum logic [1:0] {
        SRCA_RS1  = 2'b00,
        SRCA_PC   = 2'b01,
        SRCA_ZERO = 2'b10,
        SRCA_RSVD = 2'b11    // behaves as zero
    } srca_sel_e;

    typedef enum logic {
        SRCB_RS2 = 1'b0,
        SRCB_IMM = 1'b1
    } srcb_sel_e;

    // jal and jalr write the link address instead of the ALU result
    function automatic logic is_jump(input logic [3:0] br_op);
        return (br_op == BR_JAL) || (br_op == BR_JALR);
    endfunction

endpackage

// File: rtl/ysyx_exu_bru.sv
// ----------------------------------------------------------------------------
// ysyx_exu_bru
// Combinational branch resolution for the execute stage.
// Ports:
//   i_br_op   [3:0]   branch operation (none / jal / jalr / 1fff conditional)
//   i_pc      [31:0]  instruction PC
//   i_imm     [31:0]  immediate (branch/jump offset)
//   i_rs1v    [31:0]  rs1 operand (possibly forwarded)
//   i_rs2v    [31:0]  rs2 operand (possibly forwarded)
//   o_taken           redirect required
//   o_target  [31:0]  redirect PC (0 for none/undefined codes)
// ----------------------------------------------------------------------------
module ysyx_exu_bru
    import ysyx_pkg::*;
(
    input  logic [3:0]  i_br_op,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_imm,
    input  logic [31:0] i_rs1v,
    input  logic [31:0] i_rs2v,
    output logic        o_taken,
    output logic [31:0] o_target
);

    logic [31:0] w_pc_imm;
    logic [31:0] w_rs1_imm;
    logic        w_lt;
    logic        w_ltu;
    logic        w_cond_known;
    logic        w_cond;

    assign w_pc_imm  = i_pc + i_imm;
    assign w_rs1_imm = i_rs1v + i_imm;
    assign w_lt      = $signed(i_rs1v) < $signed(i_rs2v);
    assign w_ltu     = i_rs1v < i_rs2v;

    // Condition evaluation from funct3; 010/011 are not branches in RV32I
    // and are flagged so the whole entry resolves as "no redirect".
    always_comb begin
        w_cond_known = 1'b1;
        w_cond       = 1'b0;
        case (i_br_op[2:0])
            F3_BEQ:  w_cond = (i_rs1v == i_rs2v);
            F3_BNE:  w_cond = (i_rs1v != i_rs2v);
            F3_BLT:  w_cond = w_lt;
            F3_BGE:  w_cond = !w_lt;
            F3_BLTU: w_cond = w_ltu;
            F3_BGEU: w_cond = !w_ltu;
            default: w_cond_known = 1'b0;
        endcase
    end

    always_comb begin
        o_taken  = 1'b0;
        o_target = '0;
        if (i_br_op[BR_COND_BIT]) begin
            // A not-taken branch still reports its target; WBU ignores it.
            if (w_cond_known) begin
                o_taken  = w_cond;
                o_target = w_pc_imm;
            end
        end else if (i_br_op == BR_JAL) begin
            o_taken  = 1'b1;
            o_target = w_pc_imm;
        end else if (i_br_op == BR_JALR) begin
            o_taken  = 1'b1;
            o_target = {w_rs1_imm[31:1], 1'b0};
        end
    end

endmodule

// File: rtl/ysyx_exu.sv
// ----------------------------------------------------------------------------
// ysyx_exu
// Execute stage of the NPC core. Accepts one decoded instruction per
// in_valid/in_ready handshake, selects ALU operands, resolves branches and
// registers result/destination/redirect into a single output entry for WBU.
// Build option: define YSYX_EXU_FWD_EN to forward the held output entry's
// result onto rs1/rs2 when its destination matches (x0 never forwards).
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   in_valid / in_ready            IDU handshake
//   in_pc, in_rs1_val, in_rs2_val, in_imm   operands (32b)
//   in_rs1, in_rs2, in_rd          register indices (5b)
//   in_wen                         instruction writes rd
//   in_srca_sel[1:0], in_srcb_sel  operand selects
//   in_func[3:0], in_br_op[3:0]    ALU function, branch operation
//   alu_a, alu_b, alu_func         combinational drive to external ALU
//   alu_out                        ALU result for the current drive
//   out_valid / out_ready          WBU handshake
//   out_result, out_rd, out_wen    writeback entry
//   out_redirect, out_target       taken branch/jump and its target PC
// ----------------------------------------------------------------------------
module ysyx_exu
    import ysyx_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_pc,
    input  logic [31:0] in_rs1_val,
    input  logic [31:0] in_rs2_val,
    input  logic [31:0] in_imm,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [4:0]  in_rd,
    input  logic        in_wen,
    input  logic [1:0]  in_srca_sel,
    input  logic        in_srcb_sel,
    input  logic [3:0]  in_func,
    input  logic [3:0]  in_br_op,
    output logic [31:0] alu_a,
    output logic [31:0] alu_b,
    output logic [3:0]  alu_func,
    input  logic [31:0] alu_out,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_result,
    output logic [4:0]  out_rd,
    output logic        out_wen,
    output logic        out_redirect,
    output logic [31:0] out_target
);

    logic        r_out_valid;
    logic [31:0] r_out_result;
    logic [4:0]  r_out_rd;
    logic        r_out_wen;
    logic        r_out_redirect;
    logic [31:0] r_out_target;

    logic        w_accept;
    logic [31:0] w_rs1v;
    logic [31:0] w_rs2v;
    logic        w_taken;
    logic [31:0] w_target;
    logic [31:0] w_result;

    // The entry may be replaced on the same edge it drains: no bubble.
    assign in_ready = !r_out_valid || out_ready;
    assign w_accept = in_valid && in_ready;

`ifdef YSYX_EXU_FWD_EN
    logic w_fwd_rs1;
    logic w_fwd_rs2;

    // out_wen is already cleared for rd=0, so x0 can never match here.
    // Forwarding ignores out_ready: the held value is architecturally newer.
    assign w_fwd_rs1 = r_out_valid && r_out_wen && (r_out_rd == in_rs1);
    assign w_fwd_rs2 = r_out_valid && r_out_wen && (r_out_rd == in_rs2);
    assign w_rs1v    = w_fwd_rs1 ? r_out_result : in_rs1_val;
    assign w_rs2v    = w_fwd_rs2 ? r_out_result : in_rs2_val;
`else
    logic w_unused_rs_idx;

    // Register indices only matter for forwarding; hazards belong to IDU.
    assign w_unused_rs_idx = ^{in_rs1, in_rs2};
    assign w_rs1v          = in_rs1_val;
    assign w_rs2v          = in_rs2_val;
`endif

    always_comb begin
        alu_a = '0;
        case (in_srca_sel)
            SRCA_RS1: alu_a = w_rs1v;
            SRCA_PC:  alu_a = in_pc;
            default:  alu_a = '0;
        endcase
    end

    assign alu_b    = (in_srcb_sel == SRCB_IMM) ? in_imm : w_rs2v;
    assign alu_func = in_func;

    ysyx_exu_bru u_bru (
        .i_br_op  (in_br_op),
        .i_pc     (in_pc),
        .i_imm    (in_imm),
        .i_rs1v   (w_rs1v),
        .i_rs2v   (w_rs2v),
        .o_taken  (w_taken),
        .o_target (w_target)
    );

    assign w_result = is_jump(in_br_op) ? (in_pc + 32'd4) : alu_out;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_out_valid    <= 1'b0;
            r_out_result   <= '0;
            r_out_rd       <= '0;
            r_out_wen      <= 1'b0;
            r_out_redirect <= 1'b0;
            r_out_target   <= '0;
        end else if (w_accept) begin
            r_out_valid    <= 1'b1;
            r_out_result   <= w_result;
            r_out_rd       <= in_rd;
            r_out_wen      <= in_wen && (in_rd != 5'd0);
            r_out_redirect <= w_taken;
            r_out_target   <= w_target;
        end else if (r_out_valid && out_ready) begin
            // Drained with nothing behind it: payload fields hold their value.
            r_out_valid    <= 1'b0;
        end
    end

    assign out_valid    = r_out_valid;
    assign out_result   = r_out_result;
    assign out_rd       = r_out_rd;
    assign out_wen      = r_out_wen;
    assign out_redirect = r_out_redirect;
    assign out_target   = r_out_target;

endmodule

// File: tb/tb_ysyx_exu.sv
`timescale 1ns/1ps
module tb_ysyx_exu;

    // ---------------- encodings (bench-local) ----------------
    localparam logic [3:0] F_ADD = 4'b0000, F_SUB = 4'b1000, F_SLL = 4'b0001,
                           F_SLT = 4'b0010, F_SLTU = 4'b0011, F_XOR = 4'b0100,
                           F_SRL = 4'b0101, F_SRA = 4'b1101, F_OR = 4'b0110,
                           F_AND = 4'b0111, F_PASSB = 4'b1110;
    localparam logic [1:0] SA_RS1 = 2'b00, SA_PC = 2'b01, SA_ZERO = 2'b10, SA_RSV = 2'b11;

`ifdef YSYX_EXU_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_val;
        logic [31:0] rs2_val;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        wen;
        logic [1:0]  srca;
        logic        srcb;
        logic [3:0]  func;
        logic [3:0]  br_op;
    } instr_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] result;
        logic [4:0]  rd;
        logic        wen;
        logic        redirect;
        logic [31:0] target;
    } entry_t;

    typedef struct {
        instr_t ins;
        entry_t exp;
    } vec_t;

    // ---------------- DUT signals ----------------
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready;
    logic [31:0] in_pc, in_rs1_val, in_rs2_val, in_imm;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_wen;
    logic [1:0]  in_srca_sel;
    logic        in_srcb_sel;
    logic [3:0]  in_func, in_br_op;
    logic [31:0] alu_a, alu_b, alu_out;
    logic [3:0]  alu_func;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_wen, out_redirect;
    logic [31:0] out_target;

    always #5 clk = ~clk;

    ysyx_exu dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_pc(in_pc), .in_rs1_val(in_rs1_val), .in_rs2_val(in_rs2_val), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_wen(in_wen),
        .in_srca_sel(in_srca_sel), .in_srcb_sel(in_srcb_sel),
        .in_func(in_func), .in_br_op(in_br_op),
        .alu_a(alu_a), .alu_b(alu_b), .alu_func(alu_func), .alu_out(alu_out),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_rd(out_rd), .out_wen(out_wen),
        .out_redirect(out_redirect), .out_target(out_target)
    );

    // ---------------- behavioural ALU (environment + reference) ----------------
    function automatic logic [31:0] alu_ref(input logic [31:0] a, input logic [31:0] b,
                                            input logic [3:0] f);
        case (f)
            F_ADD:   return a + b;
            F_SUB:   return a - b;
            F_SLL:   return a << b[4:0];
            F_SLT:   return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            F_SLTU:  return (a < b) ? 32'd1 : 32'd0;
            F_XOR:   return a ^ b;
            F_SRL:   return a >> b[4:0];
            F_SRA:   return $unsigned($signed(a) >>> b[4:0]);
            F_OR:    return a | b;
            F_AND:   return a & b;
            F_PASSB: return b;
            default: return a ^ b ^ 32'h5A5A_5A5A;   // arbitrary: passed through as-is
        endcase
    endfunction

    always_comb alu_out = alu_ref(alu_a, alu_b, alu_func);

    // ---------------- reference model (one held entry) ----------------
    entry_t m;
    int checks = 0;
    int errors = 0;

    function automatic logic [31:0] opnd(input logic [31:0] val, input logic [4:0] idx,
                                         input entry_t cur);
        if (FWD && cur.valid && cur.wen && cur.rd == idx) return cur.result;
        return val;
    endfunction

    function automatic logic [31:0] opa(input instr_t i, input entry_t cur);
        if (i.srca == SA_RS1) return opnd(i.rs1_val, i.rs1, cur);
        if (i.srca == SA_PC)  return i.pc;
        return 32'd0;
    endfunction

    function automatic logic [31:0] opb(input instr_t i, input entry_t cur);
        return i.srcb ? i.imm : opnd(i.rs2_val, i.rs2, cur);
    endfunction

    function automatic entry_t predict(input instr_t i, input entry_t cur);
        entry_t e;
        logic [31:0] r1, r2;
        r1 = opnd(i.rs1_val, i.rs1, cur);
        r2 = opnd(i.rs2_val, i.rs2, cur);
        e.valid    = 1'b1;
        e.rd       = i.rd;
        e.wen      = i.wen && (i.rd != 5'd0);
        e.redirect = 1'b0;
        e.target   = 32'd0;
        e.result   = alu_ref(opa(i, cur), opb(i, cur), i.func);
        case (i.br_op)
            4'b0010: begin e.redirect = 1'b1; e.target = i.pc + i.imm; e.result = i.pc + 32'd4; end
            4'b0011: begin e.redirect = 1'b1; e.target = (r1 + i.imm) & 32'hFFFF_FFFE;
                           e.result = i.pc + 32'd4; end
            4'b1000: begin e.redirect = (r1 == r2); e.target = i.pc + i.imm; end
            4'b1001: begin e.redirect = (r1 != r2); e.target = i.pc + i.imm; end
            4'b1100: begin e.redirect = ($signed(r1) <  $signed(r2)); e.target = i.pc + i.imm; end
            4'b1101: begin e.redirect = ($signed(r1) >= $signed(r2)); e.target = i.pc + i.imm; end
            4'b1110: begin e.redirect = (r1 <  r2); e.target = i.pc + i.imm; end
            4'b1111: begin e.redirect = (r1 >= r2); e.target = i.pc + i.imm; end
            default: ;
        endcase
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".out_valid"},    32'(out_valid),    32'(m.valid));
        chk({tag, ".out_result"},   out_result,        m.result);
        chk({tag, ".out_rd"},       32'(out_rd),       32'(m.rd));
        chk({tag, ".out_wen"},      32'(out_wen),      32'(m.wen));
        chk({tag, ".out_redirect"}, 32'(out_redirect), 32'(m.redirect));
        chk({tag, ".out_target"},   out_target,        m.target);
    endtask

    task automatic drive(input instr_t i, input logic v, input logic r);
        in_pc = i.pc; in_rs1_val = i.rs1_val; in_rs2_val = i.rs2_val; in_imm = i.imm;
        in_rs1 = i.rs1; in_rs2 = i.rs2; in_rd = i.rd; in_wen = i.wen;
        in_srca_sel = i.srca; in_srcb_sel = i.srcb; in_func = i.func; in_br_op = i.br_op;
        in_valid = v; out_ready = r;
    endtask

    // One clock: drive, check combinational outputs, clock, check entry.
    task automatic step(input instr_t i, input logic v, input logic r);
        entry_t pred;
        logic   exp_rdy;
        @(negedge clk);
        drive(i, v, r);
        #1;
        exp_rdy = !m.valid || r;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("alu_a", alu_a, opa(i, m));
        chk("alu_b", alu_b, opb(i, m));
        chk("alu_func", 32'(alu_func), 32'(i.func));
        pred = predict(i, m);
        @(posedge clk);
        #1;
        if (v && exp_rdy) begin
            m = pred;
            $display("txn pc=%08h rd=%0d wen=%0b result=%08h redirect=%0b target=%08h",
                     i.pc, pred.rd, pred.wen, pred.result, pred.redirect, pred.target);
        end else if (m.valid && r) begin
            m.valid = 1'b0;
        end
        check_outputs("step");
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        m = '0;
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        chk("reset.in_ready", 32'(in_ready), 32'd1);
        $display("txn reset");
    endtask

    function automatic instr_t mk(input logic [31:0] pc, input logic [31:0] r1v,
                                  input logic [31:0] r2v, input logic [31:0] imm,
                                  input logic [4:0] rd, input logic wen, input logic [1:0] sa,
                                  input logic sb, input logic [3:0] f, input logic [3:0] br);
        instr_t i;
        i.pc = pc; i.rs1_val = r1v; i.rs2_val = r2v; i.imm = imm;
        i.rs1 = 5'd0; i.rs2 = 5'd0; i.rd = rd; i.wen = wen;
        i.srca = sa; i.srcb = sb; i.func = f; i.br_op = br;
        return i;
    endfunction

    function automatic entry_t ex(input logic [31:0] res, input logic [4:0] rd, input logic wen,
                                  input logic redir, input logic [31:0] tgt);
        entry_t e;
        e.valid = 1'b1; e.result = res; e.rd = rd; e.wen = wen; e.redirect = redir; e.target = tgt;
        return e;
    endfunction

    vec_t tbl[13];
    logic [3:0] funcs[12] = '{F_ADD, F_SUB, F_SLL, F_SLT, F_SLTU, F_XOR, F_SRL, F_SRA,
                              F_OR, F_AND, F_PASSB, 4'b1111};
    logic [3:0] brops[12] = '{4'b0000, 4'b0010, 4'b0011, 4'b1000, 4'b1001, 4'b1100,
                              4'b1101, 4'b1110, 4'b1111, 4'b0001, 4'b1010, 4'b0100};

    initial begin
        instr_t a, b, hold_a, hold_b;
        entry_t saved;

        // ---- vector table: {instruction, expected entry} ----
        tbl[0].ins  = mk(32'h100, 32'd5, 32'd0, 32'hFFFF_FFF9, 5'd3, 1, SA_RS1, 1, F_ADD, 4'b0000);
        tbl[0].exp  = ex(32'hFFFF_FFFE, 5'd3, 1, 0, 32'h0);
        tbl[1].ins  = mk(32'h104, 32'd5, 32'd0, 32'hFFFF_FFF9, 5'd0, 1, SA_RS1, 1, F_ADD, 4'b0000);
        tbl[1].exp  = ex(32'hFFFF_FFFE, 5'd0, 0, 0, 32'h0);
        tbl[2].ins  = mk(32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'h10, 5'd0, 0, SA_RS1, 0, F_SUB, 4'b1100);
        tbl[2].exp  = ex(32'hFFFF_FFFE, 5'd0, 0, 1, 32'h8000_0010);
        tbl[3].ins  = mk(32'h8000_0000, 32'hFFFF_FFFF, 32'd1, 32'h10, 5'd0, 0, SA_RS1, 0, F_SUB, 4'b1110);
        tbl[3].exp  = ex(32'hFFFF_FFFE, 5'd0, 0, 0, 32'h8000_0010);
        tbl[4].ins  = mk(32'h8000_0020, 32'h8000_0103, 32'd0, 32'h0, 5'd1, 1, SA_RS1, 1, F_ADD, 4'b0011);
        tbl[4].exp  = ex(32'h8000_0024, 5'd1, 1, 1, 32'h8000_0102);
        tbl[5].ins  = mk(32'h1000, 32'd0, 32'd0, 32'hFFFF_FFF0, 5'd1, 1, SA_PC, 1, F_ADD, 4'b0010);
        tbl[5].exp  = ex(32'h1004, 5'd1, 1, 1, 32'h0FF0);
        tbl[6].ins  = mk(32'h200, 32'd7, 32'd7, 32'h8, 5'd0, 0, SA_RS1, 0, F_SUB, 4'b1000);
        tbl[6].exp  = ex(32'h0, 5'd0, 0, 1, 32'h208);
        tbl[7].ins  = mk(32'h300, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFC, 5'd0, 0, SA_RS1, 0, F_SUB, 4'b1101);
        tbl[7].exp  = ex(32'hFFFF_FFFE, 5'd0, 0, 0, 32'h2FC);
        tbl[8].ins  = mk(32'h300, 32'hFFFF_FFFF, 32'd1, 32'hFFFF_FFFC, 5'd0, 0, SA_RS1, 0, F_SUB, 4'b1111);
        tbl[8].exp  = ex(32'hFFFF_FFFE, 5'd0, 0, 1, 32'h2FC);
        tbl[9].ins  = mk(32'h8000_0000, 32'd0, 32'd0, 32'h1234_5000, 5'd10, 1, SA_PC, 1, F_ADD, 4'b0000);
        tbl[9].exp  = ex(32'h9234_5000, 5'd10, 1, 0, 32'h0);
        tbl[10].ins = mk(32'h40, 32'h1111, 32'd0, 32'hABCD_E000, 5'd11, 1, SA_RSV, 1, F_ADD, 4'b0000);
        tbl[10].exp = ex(32'hABCD_E000, 5'd11, 1, 0, 32'h0);
        tbl[11].ins = mk(32'h50, 32'd1, 32'd31, 32'h44, 5'd4, 1, SA_RS1, 0, F_SLL, 4'b0001);
        tbl[11].exp = ex(32'h8000_0000, 5'd4, 1, 0, 32'h0);
        tbl[12].ins = mk(32'h400, 32'h8000_0000, 32'd4, 32'h4, 5'd9, 1, SA_RS1, 0, F_SRA, 4'b1010);
        tbl[12].exp = ex(32'hF800_0000, 5'd9, 1, 0, 32'h0);

        rst_n = 1'b0;
        drive(tbl[0].ins, 1'b1, 1'b0);
        m = '0;
        do_reset();

        // ---- table-driven vectors ----
        for (int k = 0; k < 13; k++) begin
            step(tbl[k].ins, 1'b1, 1'b1);
            chk($sformatf("tbl%0d.result", k),   out_result,          tbl[k].exp.result);
            chk($sformatf("tbl%0d.rd", k),       32'(out_rd),         32'(tbl[k].exp.rd));
            chk($sformatf("tbl%0d.wen", k),      32'(out_wen),        32'(tbl[k].exp.wen));
            chk($sformatf("tbl%0d.redirect", k), 32'(out_redirect),   32'(tbl[k].exp.redirect));
            chk($sformatf("tbl%0d.target", k),   out_target,          tbl[k].exp.target);
        end

        // ---- backpressure: entry held 3 cycles, then same-cycle replace ----
        a = mk(32'h600, 32'd10, 32'd0, 32'd20, 5'd2, 1, SA_RS1, 1, F_ADD, 4'b0000);
        b = mk(32'h604, 32'd100, 32'd0, 32'd23, 5'd7, 1, SA_RS1, 1, F_ADD, 4'b0000);
        step(a, 1'b1, 1'b1);
        saved = m;
        for (int k = 0; k < 3; k++) begin
            step(b, 1'b1, 1'b0);
            chk("bp.in_ready_low", 32'(in_ready), 32'd0);
            chk("bp.result_held", out_result, 32'd30);
            chk("bp.rd_held", 32'(out_rd), 32'(saved.rd));
        end
        step(b, 1'b1, 1'b1);
        chk("bp.replaced_result", out_result, 32'd123);
        chk("bp.replaced_rd", 32'(out_rd), 32'd7);
        step(b, 1'b0, 1'b1);
        chk("bp.drained", 32'(out_valid), 32'd0);

        // ---- forwarding from a held entry ----
        hold_a = mk(32'h700, 32'd0, 32'd0, 32'd42, 5'd5, 1, SA_ZERO, 1, F_ADD, 4'b0000);
        hold_b = mk(32'h704, 32'd0, 32'd0, 32'd0, 5'd6, 1, SA_RS1, 0, F_ADD, 4'b0000);
        hold_b.rs1 = 5'd5;
        step(hold_a, 1'b1, 1'b1);
        step(hold_b, 1'b1, 1'b0);
        chk("fwd.alu_a_while_held", alu_a, FWD ? 32'd42 : 32'd0);
        step(hold_b, 1'b1, 1'b1);
        chk("fwd.result", out_result, FWD ? 32'd42 : 32'd0);

        // ---- randomized stream against the model ----
        for (int n = 0; n < 400; n++) begin
            instr_t r;
            r.pc      = $urandom & 32'hFFFF_FFFC;
            r.rs1_val = $urandom;
            r.rs2_val = ($urandom_range(0, 3) == 0) ? r.rs1_val : $urandom;
            r.imm     = ($urandom_range(0, 1) == 1) ? $urandom : (32'($urandom_range(0, 63)) - 32'd32);
            r.rs1     = 5'($urandom_range(0, 7));
            r.rs2     = 5'($urandom_range(0, 7));
            r.rd      = 5'($urandom_range(0, 7));
            r.wen     = 1'($urandom_range(0, 1));
            r.srca    = 2'($urandom_range(0, 3));
            r.srcb    = 1'($urandom_range(0, 1));
            r.func    = funcs[$urandom_range(0, 11)];
            r.br_op   = brops[$urandom_range(0, 11)];
            step(r, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 9) < 7));
        end

        // ---- reset discards an in-flight entry ----
        step(a, 1'b1, 1'b0);
        do_reset();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
